frogger_game_ctrl: RTL and testbench
====================================

// Module: frogger_game_ctrl
// PURPOSE
//  Top-level game sequencer for Frogger. Owns lives, score, round timer, home-slot
//  occupancy and difficulty level. Consumes event pulses from the frog datapath
//  (death, home reached, row advanced). Drives frog_reset to respawn the frog and
//  freeze to stall frog/hazard motion during death, home and attract/game-over screens.
//  Clocked by the frame clock (one tick per video frame).
// PARAMETERS
//  LIVES_INIT   3     lives loaded at game start (1..3)
//  ROUND_FRAMES 1800  frames per life/round (30 s @ 60 Hz), <= 2047
//  DEATH_FRAMES 60    frames frozen in DYING
//  HOME_FRAMES  30    frames frozen in HOMED
//  SCORE_STEP   10    points per new furthest row
//  SCORE_HOME   50    points per frog homed
//  SCORE_LEVEL  200   bonus when all homes filled
//  NUM_HOMES    3     home slots (bits of home_filled)
//  MAX_LEVEL    7     level saturation value
// PORTS
//  frame_clk    in   1   clock (frame rate)
//  Reset        in   1   synchronous, active-high reset
//  start        in   1   start key, level; internally edge-detected (start & ~start_q)
//  frog_dead    in   1   1-cycle pulse: car/water collision or off-screen carry
//  frog_home    in   1   1-cycle pulse: frog entered a home slot
//  home_idx     in   2   slot index valid with frog_home (0..NUM_HOMES-1)
//  frog_advance in   1   1-cycle pulse: frog reached a new furthest row this life
//  game_state   out  3   0 ATTRACT, 1 PLAY, 2 DYING, 3 HOMED, 4 LEVEL_UP, 5 GAME_OVER
//  lives        out  2   remaining lives
//  score        out  14  binary score, saturates at 9999
//  time_left    out  11  frames left in current round
//  home_filled  out  3   bit i = slot i occupied
//  level        out  3   difficulty level for hazard-speed selection
//  frog_reset   out  1   1-cycle pulse: frog returns to start position
//  freeze       out  1   1 = hold frog and hazards
// BEHAVIOUR
//  Reset: state ATTRACT; lives=0, score=0, time_left=0, home_filled=0, level=0,
//   frog_reset=0, freeze=1, start_q=0, phase counter=0. Reset mid-game aborts all.
//  All outputs registered; an event sampled in cycle N is visible in cycle N+1.
//  freeze=0 only in PLAY. Event inputs ignored outside PLAY.
//  ATTRACT: start rise -> PLAY; load lives=LIVES_INIT, score=0, level=0,
//   home_filled=0, time_left=ROUND_FRAMES; frog_reset=1 for that cycle.
//  PLAY, per cycle, priority order:
//   1 frog_dead, or time_left==1 (expiring) -> DYING; lives-=1 (no wrap below 0).
//   2 frog_home with slot free -> HOMED; set bit, score+=SCORE_HOME.
//     frog_home on an occupied slot or home_idx>=NUM_HOMES is treated as death (1).
//   3 frog_advance -> score+=SCORE_STEP; stays PLAY. Dropped if 1 or 2 fires.
//   4 else time_left-=1.
//  DYING: freeze; phase counter runs DEATH_FRAMES cycles, then lives==0 ->
//   GAME_OVER, else PLAY with time_left=ROUND_FRAMES and frog_reset pulse.
//  HOMED: freeze; HOME_FRAMES cycles, then all NUM_HOMES bits set -> LEVEL_UP,
//   else PLAY with time reload and frog_reset pulse.
//  LEVEL_UP: single cycle; level+=1 (saturate at MAX_LEVEL), home_filled=0,
//   score+=SCORE_LEVEL; -> PLAY with time reload and frog_reset pulse.
//  GAME_OVER: freeze; score/level held; start rise -> same load as ATTRACT exit.
//   A start held high on entry does not restart (edge required).
//  frog_reset is asserted on, and only on, every transition into PLAY.
//  Score adds computed 15-bit wide and clamped to 9999.
// TESTING
//  Reset, start=1 at cycle 5 -> cycle 6: state=PLAY, lives=3, time_left=1800, frog_reset=1 for 1 cycle.
//  PLAY, frog_advance x4 -> score=40; frog_dead -> DYING, lives=2; 60 frames later PLAY, frog_reset pulse.
//  Idle in PLAY 1800 frames -> DYING on timeout, lives decremented; third death -> GAME_OVER.
//  frog_home idx 0,1,2 across lives -> HOMED each time, score+=50; after third home LEVEL_UP:
//   level=1, home_filled=0, score +200.
//  Same cycle frog_dead=1 and frog_home=1 -> DYING, home_filled unchanged. frog_home on a filled slot -> DYING.
//  score preloaded near 9990, frog_home -> score=9999. Reset mid-DYING -> ATTRACT with all reset values.

Source files
------------

// File: rtl/frogger_game_ctrl.sv
// rtl/frogger_game_ctrl.sv - Frogger game sequencer: lives, score, round timer, homes, level
module frogger_game_ctrl #(
  parameter int unsigned LIVES_INIT   = 3,
  parameter int unsigned ROUND_FRAMES = 1800,
  parameter int unsigned DEATH_FRAMES = 60,
  parameter int unsigned HOME_FRAMES  = 30,
  parameter int unsigned SCORE_STEP   = 10,
  parameter int unsigned SCORE_HOME   = 50,
  parameter int unsigned SCORE_LEVEL  = 200,
  parameter int unsigned NUM_HOMES    = 3,
  parameter int unsigned MAX_LEVEL    = 7
) (
  input  logic        frame_clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        frog_dead_i,
  input  logic        frog_home_i,
  input  logic [1:0]  home_idx_i,
  input  logic        frog_advance_i,
  output logic [2:0]  game_state_o,
  output logic [1:0]  lives_o,
  output logic [13:0] score_o,
  output logic [10:0] time_left_o,
  output logic [2:0]  home_filled_o,
  output logic [2:0]  level_o,
  output logic        frog_reset_o,
  output logic        freeze_o
);

  typedef enum logic [2:0] {
    ST_ATTRACT   = 3'd0,
    ST_PLAY      = 3'd1,
    ST_DYING     = 3'd2,
    ST_HOMED     = 3'd3,
    ST_LEVEL_UP  = 3'd4,
    ST_GAME_OVER = 3'd5
  } state_e;

  // One shared phase counter times both freeze screens, so size it for the longer one.
  localparam int unsigned PHASE_MAX = (DEATH_FRAMES > HOME_FRAMES) ? DEATH_FRAMES : HOME_FRAMES;
  localparam int unsigned PHASE_W   = $clog2(PHASE_MAX + 1);

  localparam logic [PHASE_W-1:0] DEATH_LAST = PHASE_W'(DEATH_FRAMES - 1);
  localparam logic [PHASE_W-1:0] HOME_LAST  = PHASE_W'(HOME_FRAMES - 1);
  localparam logic [10:0]        ROUND_LOAD = 11'(ROUND_FRAMES);
  localparam logic [1:0]         LIVES_LOAD = 2'(LIVES_INIT);
  localparam logic [2:0]         HOMES_ALL  = 3'((1 << NUM_HOMES) - 1);
  localparam logic [2:0]         LEVEL_CAP  = 3'(MAX_LEVEL);
  localparam logic [13:0]        ADD_STEP   = 14'(SCORE_STEP);
  localparam logic [13:0]        ADD_HOME   = 14'(SCORE_HOME);
  localparam logic [13:0]        ADD_LEVEL  = 14'(SCORE_LEVEL);
  localparam logic [14:0]        SCORE_CAP  = 15'd9999;

  state_e               state_q, state_d;
  logic [1:0]           lives_q, lives_d;
  logic [13:0]          score_q, score_d;
  logic [10:0]          time_left_q, time_left_d;
  logic [2:0]           home_filled_q, home_filled_d;
  logic [2:0]           level_q, level_d;
  logic                 frog_reset_q, frog_reset_d;
  logic                 freeze_q, freeze_d;
  logic                 start_q;
  logic [PHASE_W-1:0]   phase_q, phase_d;

  logic                 start_rise;
  logic [2:0]           home_mask;
  logic                 idx_valid;
  logic                 slot_free;
  logic                 dies;

  // Score additions are done one bit wider so the clamp sees any overflow past 9999.
  function automatic logic [13:0] sat_add(input logic [13:0] a, input logic [13:0] b);
    logic [14:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > SCORE_CAP) begin
      sat_add = SCORE_CAP[13:0];
    end else begin
      sat_add = sum[13:0];
    end
  endfunction

  assign start_rise = start_i & ~start_q;
  assign home_mask  = 3'b001 << home_idx_i;
  assign idx_valid  = (32'(home_idx_i) < NUM_HOMES);
  assign slot_free  = idx_valid && ((home_filled_q & home_mask) == 3'b000);
  // A bad home landing (occupied or nonexistent slot) kills the frog just like a collision.
  assign dies       = frog_dead_i || (time_left_q == 11'd1) || (frog_home_i && !slot_free);

  // Next-state and next-output decode; every register target defaults to hold.
  always_comb begin
    state_d       = state_q;
    lives_d       = lives_q;
    score_d       = score_q;
    time_left_d   = time_left_q;
    home_filled_d = home_filled_q;
    level_d       = level_q;
    phase_d       = phase_q;
    frog_reset_d  = 1'b0;

    case (state_q)
      ST_ATTRACT, ST_GAME_OVER: begin
        if (start_rise) begin
          state_d       = ST_PLAY;
          lives_d       = LIVES_LOAD;
          score_d       = 14'd0;
          level_d       = 3'd0;
          home_filled_d = 3'b000;
          time_left_d   = ROUND_LOAD;
          frog_reset_d  = 1'b1;
        end
      end

      ST_PLAY: begin
        if (dies) begin
          state_d = ST_DYING;
          phase_d = '0;
          if (lives_q != 2'd0) begin
            lives_d = lives_q - 2'd1;
          end
        end else if (frog_home_i) begin
          state_d       = ST_HOMED;
          phase_d       = '0;
          home_filled_d = home_filled_q | home_mask;
          score_d       = sat_add(score_q, ADD_HOME);
        end else if (frog_advance_i) begin
          score_d = sat_add(score_q, ADD_STEP);
        end else begin
          time_left_d = time_left_q - 11'd1;
        end
      end

      ST_DYING: begin
        if (phase_q == DEATH_LAST) begin
          phase_d = '0;
          if (lives_q == 2'd0) begin
            state_d = ST_GAME_OVER;
          end else begin
            state_d      = ST_PLAY;
            time_left_d  = ROUND_LOAD;
            frog_reset_d = 1'b1;
          end
        end else begin
          phase_d = phase_q + PHASE_W'(1);
        end
      end

      ST_HOMED: begin
        if (phase_q == HOME_LAST) begin
          phase_d = '0;
          if (home_filled_q == HOMES_ALL) begin
            state_d = ST_LEVEL_UP;
          end else begin
            state_d      = ST_PLAY;
            time_left_d  = ROUND_LOAD;
            frog_reset_d = 1'b1;
          end
        end else begin
          phase_d = phase_q + PHASE_W'(1);
        end
      end

      ST_LEVEL_UP: begin
        if (level_q < LEVEL_CAP) begin
          level_d = level_q + 3'd1;
        end
        home_filled_d = 3'b000;
        score_d       = sat_add(score_q, ADD_LEVEL);
        state_d       = ST_PLAY;
        time_left_d   = ROUND_LOAD;
        frog_reset_d  = 1'b1;
      end

      default: begin
        state_d = ST_ATTRACT;
      end
    endcase

    // Motion runs only while the next state is PLAY, keeping freeze aligned with game_state.
    freeze_d = (state_d != ST_PLAY);
  end

  // State and output registers with synchronous reset that aborts any game in progress.
  always_ff @(posedge frame_clk_i) begin
    if (reset_i) begin
      state_q       <= ST_ATTRACT;
      lives_q       <= 2'd0;
      score_q       <= 14'd0;
      time_left_q   <= 11'd0;
      home_filled_q <= 3'b000;
      level_q       <= 3'd0;
      frog_reset_q  <= 1'b0;
      freeze_q      <= 1'b1;
      start_q       <= 1'b0;
      phase_q       <= '0;
    end else begin
      state_q       <= state_d;
      lives_q       <= lives_d;
      score_q       <= score_d;
      time_left_q   <= time_left_d;
      home_filled_q <= home_filled_d;
      level_q       <= level_d;
      frog_reset_q  <= frog_reset_d;
      freeze_q      <= freeze_d;
      start_q       <= start_i;
      phase_q       <= phase_d;
    end
  end

  assign game_state_o  = state_q;
  assign lives_o       = lives_q;
  assign score_o       = score_q;
  assign time_left_o   = time_left_q;
  assign home_filled_o = home_filled_q;
  assign level_o       = level_q;
  assign frog_reset_o  = frog_reset_q;
  assign freeze_o      = freeze_q;

endmodule

// File: tb/tb_frogger_game_ctrl.sv
// tb/tb_frogger_game_ctrl.sv - bench for frogger_game_ctrl against a frame-level game model
module tb_frogger_game_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        dead = 1'b0;
  logic        home = 1'b0;
  logic        adv = 1'b0;
  logic [1:0]  idx = 2'd0;
  logic [2:0]  game_state;
  logic [1:0]  lives;
  logic [13:0] score;
  logic [10:0] time_left;
  logic [2:0]  home_filled;
  logic [2:0]  level;
  logic        frog_reset;
  logic        freeze;

  int checks = 0;
  int errors = 0;

  // Game model: spec codes for the screen, countdown of frozen frames left on the screen.
  int m_state, m_lives, m_score, m_time, m_homes, m_level, m_wait;
  bit m_fr, m_fz, m_sprev;

  frogger_game_ctrl dut (
    .frame_clk_i    (clk),
    .reset_i        (rst),
    .start_i        (start),
    .frog_dead_i    (dead),
    .frog_home_i    (home),
    .home_idx_i     (idx),
    .frog_advance_i (adv),
    .game_state_o   (game_state),
    .lives_o        (lives),
    .score_o        (score),
    .time_left_o    (time_left),
    .home_filled_o  (home_filled),
    .level_o        (level),
    .frog_reset_o   (frog_reset),
    .freeze_o       (freeze)
  );

  initial forever #5 clk = ~clk;

  function automatic int addsat(input int a, input int b);
    return (a + b > 9999) ? 9999 : a + b;
  endfunction

  task automatic respawn();
    m_state = 1; m_time = 1800; m_fr = 1;
  endtask

  task automatic model_step();
    bit rise;
    bit bad;
    rise = start && !m_sprev;
    m_sprev = start;
    m_fr = 0;
    if (rst) begin
      m_state = 0; m_lives = 0; m_score = 0; m_time = 0; m_homes = 0;
      m_level = 0; m_wait = 0; m_sprev = 0; m_fz = 1;
      return;
    end
    if (m_state == 0 || m_state == 5) begin
      if (rise) begin
        m_lives = 3; m_score = 0; m_level = 0; m_homes = 0;
        respawn();
      end
    end else if (m_state == 1) begin
      bad = home && (idx >= 3 || ((m_homes >> idx) & 1) == 1);
      if (dead || m_time == 1 || bad) begin
        m_state = 2; m_wait = 60;
        if (m_lives > 0) m_lives--;
      end else if (home) begin
        m_state = 3; m_wait = 30;
        m_homes = m_homes | (1 << idx);
        m_score = addsat(m_score, 50);
      end else if (adv) begin
        m_score = addsat(m_score, 10);
      end else begin
        m_time--;
      end
    end else if (m_state == 2) begin
      m_wait--;
      if (m_wait == 0) begin
        if (m_lives == 0) m_state = 5;
        else respawn();
      end
    end else if (m_state == 3) begin
      m_wait--;
      if (m_wait == 0) begin
        if (m_homes == 7) m_state = 4;
        else respawn();
      end
    end else begin
      m_level = (m_level < 7) ? m_level + 1 : 7;
      m_homes = 0;
      m_score = addsat(m_score, 200);
      respawn();
    end
    m_fz = (m_state != 1);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wait_while(input int st, input int limit, output int n);
    n = 0;
    while (game_state == 3'(st) && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic do_start();
    rst = 1; start = 0; dead = 0; home = 0; adv = 0; idx = 0;
    tick();
    rst = 0; start = 1;
    tick();
    start = 0;
  endtask

  task automatic test_reset();
    rst = 1; start = 0; dead = 0; home = 0; adv = 0;
    tick(); tick();
    checks++; if (game_state !== 3'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", game_state); end
    checks++; if (lives !== 2'd0) begin errors++; $display("FAIL rst_lives got=%0d exp=0", lives); end
    checks++; if (score !== 14'd0) begin errors++; $display("FAIL rst_score got=%0d exp=0", score); end
    checks++; if (time_left !== 11'd0) begin errors++; $display("FAIL rst_time got=%0d exp=0", time_left); end
    checks++; if (home_filled !== 3'd0 || level !== 3'd0) begin errors++; $display("FAIL rst_home_level got=%0d/%0d exp=0/0", home_filled, level); end
    checks++; if (frog_reset !== 1'b0 || freeze !== 1'b1) begin errors++; $display("FAIL rst_fr_fz got=%0b/%0b exp=0/1", frog_reset, freeze); end
    rst = 0;
    repeat (4) tick();
    start = 1;
    tick();
    checks++; if (game_state !== 3'd1) begin errors++; $display("FAIL start_state got=%0d exp=1", game_state); end
    checks++; if (lives !== 2'd3 || time_left !== 11'd1800) begin errors++; $display("FAIL start_load got=%0d/%0d exp=3/1800", lives, time_left); end
    checks++; if (frog_reset !== 1'b1 || freeze !== 1'b0) begin errors++; $display("FAIL start_fr_fz got=%0b/%0b exp=1/0", frog_reset, freeze); end
    start = 0;
    tick();
    checks++; if (frog_reset !== 1'b0 || time_left !== 11'd1799) begin errors++; $display("FAIL start_next got=%0b/%0d exp=0/1799", frog_reset, time_left); end
  endtask

  task automatic test_advance_death();
    int n;
    do_start();
    adv = 1;
    repeat (4) tick();
    adv = 0;
    checks++; if (score !== 14'd40 || time_left !== 11'd1800) begin errors++; $display("FAIL adv_score got=%0d/%0d exp=40/1800", score, time_left); end
    dead = 1;
    tick();
    dead = 0;
    checks++; if (game_state !== 3'd2 || lives !== 2'd2 || freeze !== 1'b1) begin errors++; $display("FAIL death got=%0d/%0d/%0b exp=2/2/1", game_state, lives, freeze); end
    wait_while(2, 200, n);
    checks++; if (n != 60) begin errors++; $display("FAIL death_frames got=%0d exp=60", n); end
    checks++; if (game_state !== 3'd1 || frog_reset !== 1'b1 || time_left !== 11'd1800) begin errors++; $display("FAIL respawn got=%0d/%0b/%0d exp=1/1/1800", game_state, frog_reset, time_left); end
  endtask

  task automatic test_timeout();
    int n;
    do_start();
    for (int r = 0; r < 3; r++) begin
      wait_while(1, 2000, n);
      checks++; if (n != 1800) begin errors++; $display("FAIL timeout_frames round=%0d got=%0d exp=1800", r, n); end
      checks++; if (game_state !== 3'd2 || lives !== 2'(2 - r)) begin errors++; $display("FAIL timeout_death round=%0d got=%0d/%0d exp=2/%0d", r, game_state, lives, 2 - r); end
      if (r == 2) start = 1;
      wait_while(2, 200, n);
      checks++; if (n != 60) begin errors++; $display("FAIL timeout_dying round=%0d got=%0d exp=60", r, n); end
    end
    checks++; if (game_state !== 3'd5 || lives !== 2'd0 || freeze !== 1'b1) begin errors++; $display("FAIL game_over got=%0d/%0d/%0b exp=5/0/1", game_state, lives, freeze); end
    repeat (5) tick();
    checks++; if (game_state !== 3'd5) begin errors++; $display("FAIL held_start got=%0d exp=5", game_state); end
    start = 0;
    tick();
    start = 1;
    tick();
    start = 0;
    checks++; if (game_state !== 3'd1 || lives !== 2'd3 || score !== 14'd0 || frog_reset !== 1'b1) begin errors++; $display("FAIL restart got=%0d/%0d/%0d/%0b exp=1/3/0/1", game_state, lives, score, frog_reset); end
  endtask

  task automatic test_homes();
    int n;
    do_start();
    for (int k = 0; k < 3; k++) begin
      home = 1; idx = 2'(k);
      tick();
      home = 0;
      checks++; if (game_state !== 3'd3 || score !== 14'(50 * (k + 1)) || home_filled !== 3'((1 << (k + 1)) - 1)) begin errors++; $display("FAIL homed k=%0d got=%0d/%0d/%0d exp=3/%0d/%0d", k, game_state, score, home_filled, 50 * (k + 1), (1 << (k + 1)) - 1); end
      wait_while(3, 100, n);
      checks++; if (n != 30) begin errors++; $display("FAIL home_frames k=%0d got=%0d exp=30", k, n); end
      if (k < 2) begin
        checks++; if (game_state !== 3'd1 || frog_reset !== 1'b1) begin errors++; $display("FAIL home_respawn k=%0d got=%0d/%0b exp=1/1", k, game_state, frog_reset); end
      end
    end
    checks++; if (game_state !== 3'd4) begin errors++; $display("FAIL level_up_state got=%0d exp=4", game_state); end
    tick();
    checks++; if (game_state !== 3'd1 || level !== 3'd1 || home_filled !== 3'd0 || score !== 14'd350 || frog_reset !== 1'b1) begin errors++; $display("FAIL level_up got=%0d/%0d/%0d/%0d/%0b exp=1/1/0/350/1", game_state, level, home_filled, score, frog_reset); end
  endtask

  task automatic test_conflicts();
    int n;
    do_start();
    dead = 1; home = 1; idx = 0; adv = 1;
    tick();
    dead = 0; home = 0; adv = 0;
    checks++; if (game_state !== 3'd2 || home_filled !== 3'd0 || score !== 14'd0 || lives !== 2'd2) begin errors++; $display("FAIL dead_and_home got=%0d/%0d/%0d/%0d exp=2/0/0/2", game_state, home_filled, score, lives); end
    wait_while(2, 200, n);
    home = 1; idx = 0;
    tick();
    home = 0;
    wait_while(3, 100, n);
    home = 1; idx = 0;
    tick();
    home = 0;
    checks++; if (game_state !== 3'd2 || home_filled !== 3'd1 || lives !== 2'd1 || score !== 14'd50) begin errors++; $display("FAIL filled_slot got=%0d/%0d/%0d/%0d exp=2/1/1/50", game_state, home_filled, lives, score); end
    wait_while(2, 200, n);
    home = 1; idx = 3;
    tick();
    home = 0;
    checks++; if (game_state !== 3'd2 || lives !== 2'd0 || home_filled !== 3'd1) begin errors++; $display("FAIL bad_idx got=%0d/%0d/%0d exp=2/0/1", game_state, lives, home_filled); end
    wait_while(2, 200, n);
    checks++; if (game_state !== 3'd5) begin errors++; $display("FAIL bad_idx_over got=%0d exp=5", game_state); end
  endtask

  task automatic test_saturation();
    int n;
    do_start();
    adv = 1;
    repeat (999) tick();
    adv = 0;
    checks++; if (score !== 14'd9990 || time_left !== 11'd1800) begin errors++; $display("FAIL near_cap got=%0d/%0d exp=9990/1800", score, time_left); end
    home = 1; idx = 1;
    tick();
    home = 0;
    checks++; if (score !== 14'd9999 || game_state !== 3'd3) begin errors++; $display("FAIL cap_home got=%0d/%0d exp=9999/3", score, game_state); end
    wait_while(3, 100, n);
    adv = 1;
    tick();
    adv = 0;
    checks++; if (score !== 14'd9999) begin errors++; $display("FAIL cap_adv got=%0d exp=9999", score); end
    dead = 1;
    tick();
    dead = 0;
    repeat (10) tick();
    rst = 1;
    tick();
    checks++; if ({game_state, lives, score, time_left, home_filled, level, frog_reset, freeze} !== {3'd0, 2'd0, 14'd0, 11'd0, 3'd0, 3'd0, 1'b0, 1'b1}) begin errors++; $display("FAIL mid_dying_reset got=%0d/%0d/%0d/%0d/%0d/%0d/%0b/%0b exp=0/0/0/0/0/0/0/1", game_state, lives, score, time_left, home_filled, level, frog_reset, freeze); end
    rst = 0;
  endtask

  task automatic test_random();
    logic [37:0] exp_v;
    rst = 1;
    tick();
    rst = 0;
    for (int c = 0; c < 4000; c++) begin
      rst   = ($urandom_range(0, 1999) == 0);
      start = ($urandom_range(0, 15) == 0);
      dead  = ($urandom_range(0, 99) == 0);
      home  = ($urandom_range(0, 39) == 0);
      idx   = 2'($urandom_range(0, 3));
      adv   = ($urandom_range(0, 3) == 0);
      tick();
      exp_v = {3'(m_state), 2'(m_lives), 14'(m_score), 11'(m_time), 3'(m_homes), 3'(m_level), m_fr, m_fz};
      checks++;
      if ({game_state, lives, score, time_left, home_filled, level, frog_reset, freeze} !== exp_v) begin
        errors++;
        $display("FAIL random cyc=%0d got=%0d/%0d/%0d/%0d/%0d/%0d/%0b/%0b exp=%0d/%0d/%0d/%0d/%0d/%0d/%0b/%0b", c,
                 game_state, lives, score, time_left, home_filled, level, frog_reset, freeze,
                 m_state, m_lives, m_score, m_time, m_homes, m_level, m_fr, m_fz);
      end
    end
    rst = 0; start = 0; dead = 0; home = 0; adv = 0;
  endtask

  initial begin
    test_reset();
    test_advance_death();
    test_timeout();
    test_homes();
    test_conflicts();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
